// File: rtl/ahb_mtx_pkg.sv
// Shared AHB encodings and helpers for the bus-matrix output arbiter.
// Optional round-robin arbitration is selected with AHB_MTX_ARB_ROUND_ROBIN_EN.
package ahb_mtx_pkg;

  localparam int unsigned ARB_MAX_PORTS = 8;

  typedef enum logic [1:0] {
    HtransIdle   = 2'b00,
    HtransBusy   = 2'b01,
    HtransNonseq = 2'b10,
    HtransSeq    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HburstSingle = 3'b000,
    HburstIncr   = 3'b001,
    HburstWrap4  = 3'b010,
    HburstIncr4  = 3'b011,
    HburstWrap8  = 3'b100,
    HburstIncr8  = 3'b101,
    HburstWrap16 = 3'b110,
    HburstIncr16 = 3'b111
  } hburst_e;

  // Beats remaining after the first beat of a burst; undefined-length bursts count as 0.
  function automatic logic [3:0] burst_beats_m1(input logic [2:0] hburst);
    logic [3:0] beats;
    case (hburst)
      HburstWrap4,  HburstIncr4:  beats = 4'd3;
      HburstWrap8,  HburstIncr8:  beats = 4'd7;
      HburstWrap16, HburstIncr16: beats = 4'd15;
      default:                    beats = 4'd0;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/ahb_mtx_prio_pick.sv
// Circular priority picker: returns the first set candidate at or after start_i.
module ahb_mtx_prio_pick #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned PORT_W    = 3
) (
  input  logic [NUM_PORTS-1:0] cand_i,
  input  logic [PORT_W-1:0]    start_i,
  output logic                 found_o,
  output logic [PORT_W-1:0]    idx_o
);

  always_comb begin
    logic                 hit;
    logic [PORT_W-1:0]    idx;
    logic [NUM_PORTS-1:0] shifted;
    int unsigned          pos;
    hit     = 1'b0;
    idx     = '0;
    shifted = '0;
    pos     = 0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      pos     = (32'(start_i) + k) % NUM_PORTS;
      shifted = cand_i >> pos;
      if (!hit && shifted[0]) begin
        hit = 1'b1;
        idx = PORT_W'(pos);
      end
    end
    found_o = hit;
    idx_o   = idx;
  end

endmodule

// File: rtl/ahb_mtx_out_arb_n.sv
// AHB bus-matrix output-stage arbiter with burst-aware grant holding.
// Define AHB_MTX_ARB_ROUND_ROBIN_EN for round-robin instead of fixed priority.
module ahb_mtx_out_arb_n
  import ahb_mtx_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned PORT_W    = 3
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [NUM_PORTS-1:0] req_port,
  input  logic                 HREADYM,
  input  logic                 HSELM,
  input  logic [1:0]           HTRANSM,
  input  logic [2:0]           HBURSTM,
  input  logic                 HMASTLOCKM,
  output logic [PORT_W-1:0]    addr_in_port,
  output logic                 no_port,
  output logic                 arb_hold
);

  logic [PORT_W-1:0]    addr_in_port_q, addr_in_port_d;
  logic                 no_port_q, no_port_d;
  logic [3:0]           burst_cnt_q, burst_cnt_d;
  logic                 arb_hold_q, arb_hold_d;

  logic                 act_cur;
  logic [3:0]           cnt_nxt;
  logic [NUM_PORTS-1:0] cand;
  logic [PORT_W-1:0]    pick_start;
  logic                 pick_found;
  logic [PORT_W-1:0]    pick_idx;
  logic                 grant;

  assign act_cur = HSELM && (HTRANSM != HtransIdle);

  // The port currently driving the slave keeps competing while its transfer is active.
  assign cand = req_port | ({{(NUM_PORTS-1){1'b0}}, act_cur} << addr_in_port_q);

  always_comb begin
    cnt_nxt = 4'd0;
    if (HSELM) begin
      case (HTRANSM)
        HtransNonseq: cnt_nxt = burst_beats_m1(HBURSTM);
        HtransSeq:    cnt_nxt = (burst_cnt_q != 4'd0) ? burst_cnt_q - 4'd1 : 4'd0;
        HtransBusy:   cnt_nxt = burst_cnt_q;
        default:      cnt_nxt = 4'd0;
      endcase
    end
  end

`ifdef AHB_MTX_ARB_ROUND_ROBIN_EN
  logic [PORT_W-1:0] last_grant_q, last_grant_d;

  assign pick_start = (last_grant_q == PORT_W'(NUM_PORTS - 1)) ? '0 : last_grant_q + 1'b1;
  assign last_grant_d = grant ? pick_idx : last_grant_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      last_grant_q <= PORT_W'(NUM_PORTS - 1);
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  assign pick_start = '0;
`endif

  ahb_mtx_prio_pick #(
    .NUM_PORTS (NUM_PORTS),
    .PORT_W    (PORT_W)
  ) u_prio_pick (
    .cand_i  (cand),
    .start_i (pick_start),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    addr_in_port_d = addr_in_port_q;
    no_port_d      = no_port_q;
    burst_cnt_d    = burst_cnt_q;
    arb_hold_d     = arb_hold_q;
    grant          = 1'b0;
    if (HREADYM) begin
      burst_cnt_d = cnt_nxt;
      arb_hold_d  = (cnt_nxt != 4'd0);
      if (HMASTLOCKM || (cnt_nxt != 4'd0)) begin
        no_port_d = 1'b0;
      end else if (pick_found) begin
        addr_in_port_d = pick_idx;
        no_port_d      = 1'b0;
        grant          = 1'b1;
      end else begin
        // An address phase still selecting this slave keeps the current owner.
        no_port_d = !HSELM;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_in_port_q <= '0;
      no_port_q      <= 1'b1;
      burst_cnt_q    <= 4'd0;
      arb_hold_q     <= 1'b0;
    end else begin
      addr_in_port_q <= addr_in_port_d;
      no_port_q      <= no_port_d;
      burst_cnt_q    <= burst_cnt_d;
      arb_hold_q     <= arb_hold_d;
    end
  end

  assign addr_in_port = addr_in_port_q;
  assign no_port      = no_port_q;
  assign arb_hold     = arb_hold_q;

endmodule

// File: tb/tb_ahb_mtx_out_arb_n.sv
// Bench for ahb_mtx_out_arb_n: directed scenarios plus randomized traffic vs a behavioural model.
module tb_ahb_mtx_out_arb_n;

  localparam int unsigned NP = 4;
  localparam int unsigned PW = 3;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic [NP-1:0] req_port;
  logic          HREADYM;
  logic          HSELM;
  logic [1:0]    HTRANSM;
  logic [2:0]    HBURSTM;
  logic          HMASTLOCKM;
  logic [PW-1:0] addr_in_port;
  logic          no_port;
  logic          arb_hold;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  ahb_mtx_out_arb_n #(
    .NUM_PORTS (NP),
    .PORT_W    (PW)
  ) dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .req_port     (req_port),
    .HREADYM      (HREADYM),
    .HSELM        (HSELM),
    .HTRANSM      (HTRANSM),
    .HBURSTM      (HBURSTM),
    .HMASTLOCKM   (HMASTLOCKM),
    .addr_in_port (addr_in_port),
    .no_port      (no_port),
    .arb_hold     (arb_hold)
  );

  always #5 HCLK = ~HCLK;

  // Model state: owner, idle flag, beats still to come, last granted port.
  typedef struct {
    int port;
    bit nop;
    int left;
    int last;
  } mstate_t;

  mstate_t ms = '{port: 0, nop: 1'b1, left: 0, last: NP - 1};

  function automatic int burst_len(input logic [2:0] hb);
    if (hb < 3'd2) return 1;
    return 4 << ((int'(hb) - 2) / 2);
  endfunction

  function automatic mstate_t model_step(input mstate_t s);
    mstate_t       n;
    bit            act;
    int            start;
    int            p;
    logic [NP-1:0] r;
    n   = s;
    act = HSELM && (HTRANSM != 2'b00);
    if (!HSELM || HTRANSM == 2'b00) n.left = 0;
    else if (HTRANSM == 2'b10) n.left = burst_len(HBURSTM) - 1;
    else if (HTRANSM == 2'b11) n.left = (s.left > 0) ? s.left - 1 : 0;
    if (HMASTLOCKM || n.left > 0) begin
      n.nop = 1'b0;
      return n;
    end
`ifdef AHB_MTX_ARB_ROUND_ROBIN_EN
    start = (s.last + 1) % NP;
`else
    start = 0;
`endif
    for (int k = 0; k < NP; k++) begin
      p = (start + k) % NP;
      r = req_port >> p;
      if (r[0] || (p == s.port && act)) begin
        n.port = p;
        n.nop  = 1'b0;
        n.last = p;
        return n;
      end
    end
    n.nop = !HSELM;
    return n;
  endfunction

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ms <= '{port: 0, nop: 1'b1, left: 0, last: NP - 1};
    end else if (HREADYM) begin
      ms <= model_step(ms);
    end
  end

  always @(negedge HCLK) begin
    if (cmp_en) begin
      checks++;
      if (addr_in_port !== PW'(ms.port) || no_port !== ms.nop || arb_hold !== (ms.left > 0)) begin
        failures++;
        $display("FAIL model_cmp t=%0t got addr=%0d no_port=%0b hold=%0b want addr=%0d no_port=%0b hold=%0b",
                 $time, addr_in_port, no_port, arb_hold, ms.port, ms.nop, (ms.left > 0));
      end
    end
  end

  task automatic chk(input string name, input int ea, input bit en, input bit eh);
    checks++;
    if (addr_in_port !== PW'(ea) || no_port !== en || arb_hold !== eh) begin
      failures++;
      $display("FAIL %s t=%0t got addr=%0d no_port=%0b hold=%0b want addr=%0d no_port=%0b hold=%0b",
               name, $time, addr_in_port, no_port, arb_hold, ea, en, eh);
    end
  endtask

  task automatic drv(input logic [NP-1:0] r, input logic rdy, input logic sel,
                     input logic [1:0] tr, input logic [2:0] bu, input logic lk);
    req_port   = r;
    HREADYM    = rdy;
    HSELM      = sel;
    HTRANSM    = tr;
    HBURSTM    = bu;
    HMASTLOCKM = lk;
  endtask

  initial begin
    logic [NP-1:0] r;
    logic [1:0]    tr;
    logic          sel;
    int            exp_port;

    HRESETn = 1'b0;
    drv(4'b0000, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0);
    cmp_en = 1'b1;
    repeat (2) @(negedge HCLK);
    chk("reset_values", 0, 1'b1, 1'b0);
    #1 HRESETn = 1'b1;

    // Fixed priority pick and release.
    drv(4'b1010, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0);
    @(negedge HCLK); chk("prio_pick_1010", 1, 1'b0, 1'b0);
    drv(4'b0000, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0);
    @(negedge HCLK); chk("no_request", 1, 1'b1, 1'b0);

    // INCR8 from port 2; port 0 joins from beat 2.
    drv(4'b0100, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0);
    @(negedge HCLK); chk("grant_port2", 2, 1'b0, 1'b0);
    drv(4'b0100, 1'b1, 1'b1, 2'b10, 3'b101, 1'b0);
    @(negedge HCLK); chk("incr8_beat1", 2, 1'b0, 1'b1);
    for (int b = 2; b <= 8; b++) begin
      drv(4'b0101, 1'b1, 1'b1, 2'b11, 3'b101, 1'b0);
      @(negedge HCLK);
      if (b < 8) chk("incr8_hold", 2, 1'b0, 1'b1);
      else       chk("incr8_release", 0, 1'b0, 1'b0);
    end

    // WRAP4 terminated early by IDLE.
    drv(4'b0100, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0);
    @(negedge HCLK); chk("grant_port2_b", 2, 1'b0, 1'b0);
    drv(4'b0101, 1'b1, 1'b1, 2'b10, 3'b010, 1'b0);
    @(negedge HCLK); chk("wrap4_nonseq", 2, 1'b0, 1'b1);
    drv(4'b0101, 1'b1, 1'b1, 2'b11, 3'b010, 1'b0);
    @(negedge HCLK); chk("wrap4_seq", 2, 1'b0, 1'b1);
    drv(4'b0101, 1'b1, 1'b1, 2'b00, 3'b010, 1'b0);
    @(negedge HCLK); chk("early_term", 0, 1'b0, 1'b0);

    // Lock holds the grant; wait states freeze everything.
    drv(4'b1000, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0);
    @(negedge HCLK); chk("grant_port3", 3, 1'b0, 1'b0);
    drv(4'b1111, 1'b1, 1'b1, 2'b10, 3'b000, 1'b1);
    @(negedge HCLK); chk("lock_single", 3, 1'b0, 1'b0);
    drv(4'b1111, 1'b1, 1'b1, 2'b10, 3'b011, 1'b1);
    @(negedge HCLK); chk("lock_incr4", 3, 1'b0, 1'b1);
    drv(4'b0001, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0);
    repeat (3) begin
      @(negedge HCLK); chk("wait_state_hold", 3, 1'b0, 1'b1);
    end
    drv(4'b0001, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0);
    @(negedge HCLK); chk("after_wait", 0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of an INCR16.
    drv(4'b0010, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0);
    @(negedge HCLK); chk("grant_port1", 1, 1'b0, 1'b0);
    drv(4'b0011, 1'b1, 1'b1, 2'b10, 3'b111, 1'b0);
    @(negedge HCLK); chk("incr16_beat1", 1, 1'b0, 1'b1);
    drv(4'b0011, 1'b1, 1'b1, 2'b11, 3'b111, 1'b0);
    @(negedge HCLK); chk("incr16_beat2", 1, 1'b0, 1'b1);
    @(posedge HCLK);
    #2 HRESETn = 1'b0;
    #1 chk("async_reset", 0, 1'b1, 1'b0);
    @(negedge HCLK);
    drv(4'b0000, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0);
    #1 HRESETn = 1'b1;

    // All ports requesting with SINGLE transfers.
    drv(4'b1111, 1'b1, 1'b1, 2'b10, 3'b000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge HCLK);
`ifdef AHB_MTX_ARB_ROUND_ROBIN_EN
      exp_port = i % NP;
`else
      exp_port = 0;
`endif
      chk("all_request_seq", exp_port, 1'b0, 1'b0);
    end

    // Randomized traffic, checked every cycle by the model compare.
    for (int i = 0; i < 3000; i++) begin
      @(negedge HCLK);
      HRESETn = 1'b1;
      r   = NP'($urandom);
      if ($urandom_range(0, 9) < 3) r = '0;
      tr  = 2'($urandom_range(0, 3));
      sel = ($urandom_range(0, 7) != 0);
      if (ms.left > 0 && $urandom_range(0, 3) != 0) begin
        tr  = 2'b11;
        sel = 1'b1;
      end
      drv(r, ($urandom_range(0, 3) != 0), sel, tr, 3'($urandom_range(0, 7)),
          ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 499) == 0) #2 HRESETn = 1'b0;
    end

    @(negedge HCLK);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_mtx_out_arb_n.md
# ahb_mtx_out_arb_n

Parametrised output-stage arbiter for the AHB bus matrix. Each instance selects which of `NUM_PORTS` input stages drives one shared slave port, and it updates only when `HREADYM` is high. It extends the two-port fixed-priority arbiter with a configurable port count and burst-aware grant holding for defined-length bursts. A compile-time round-robin mode is also available.

## Interface
- `NUM_PORTS`, default 4: number of input ports requesting this slave; legal range 2..8.
- `PORT_W`, default 3: width of `addr_in_port`; must satisfy 2^PORT_W >= NUM_PORTS.
- `HCLK`  in  1  AHB clock; all state updates on its rising edge.
- `HRESETn`  in  1  reset; asynchronous and active-low.
- `req_port`  in  NUM_PORTS  per-port request, bit i is port i.
- `HREADYM`  in  1  slave-side transfer done; the arbiter registers update only when it is 1.
- `HSELM`  in  1  slave select of the currently driven address phase.
- `HTRANSM`  in  2  transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- `HBURSTM`  in  3  burst type, standard AHB encoding.
- `HMASTLOCKM`  in  1  locked transfer.
- `addr_in_port`  out  PORT_W  selected port index.
- `no_port`  out  1  no input port selected.
- `arb_hold`  out  1  registered flag: grant is frozen because a burst has beats remaining.

## Operation
- **Active term:** `act_cur` = `HSELM` & (`HTRANSM` != IDLE). The current port counts as requesting when `act_cur` is true.
- **Burst beat counter:** `burst_cnt` is 4 bits and holds the beats remaining after the last accepted beat. Its next value, `cnt_nxt`, is computed as follows:
  - NONSEQ & `HSELM`: load beats-1. WRAP4/INCR4 load 3, WRAP8/INCR8 load 7, WRAP16/INCR16 load 15, SINGLE/INCR load 0.
  - SEQ with `burst_cnt` != 0: decrement.
  - BUSY: unchanged.
  - IDLE, or `HSELM`=0: clear to 0. This covers early termination.
- **Priority of next-state rules** (first match wins):
  1. `HMASTLOCKM`: hold `addr_in_port`; `no_port_next`=0.
  2. `cnt_nxt` != 0: hold `addr_in_port`; `no_port_next`=0.
  3. Candidate set = `req_port`, with bit[cur] ORed with `act_cur`. If the set is non-empty, grant the highest-priority candidate; `no_port_next`=0.
  4. `HSELM` high: hold `addr_in_port`; `no_port_next`=0.
  5. Otherwise: `no_port_next`=1 and `addr_in_port` is unchanged.
- **Fixed-priority mode:** port 0 is highest priority, then port 1, and so on.
- **Register update:** on an `HREADYM`=1 edge, `addr_in_port`, `no_port`, `burst_cnt` and `arb_hold` (= `cnt_nxt` != 0) load their next values. When `HREADYM`=0, every register holds.
- **Out-of-range requests:** bits of `req_port` at indices >= `NUM_PORTS` do not exist. Indices beyond `NUM_PORTS` are never granted.

## Timing
- **Reset values:** `no_port`=1, `addr_in_port`=0, `arb_hold`=0, `burst_cnt`=0, round-robin pointer=`NUM_PORTS`-1.
- **Latency:** a request seen at an `HREADYM`=1 edge is reflected in `addr_in_port` one cycle later.
- **Wait states:** a request arriving while `HREADYM`=0 waits for the next `HREADYM`=1 edge.
- **Bursts:** a defined-length burst of N beats keeps the grant through all N address phases. Re-arbitration happens at the edge that accepts the last beat.
- **Simultaneous lock and burst end:** lock takes precedence.
- **Simultaneous requests:** resolved purely by priority; there is no lost request and no bubble cycle.
- **Reset mid-burst:** all state returns to reset values immediately; the burst is not resumed.

## Configuration
- Macro: `AHB_MTX_ARB_ROUND_ROBIN_EN`.
- **Defined:** a PORT_W-bit pointer `last_grant` updates to the granted index whenever rule 3 grants on an `HREADYM`=1 edge. Priority search starts at `last_grant`+1 modulo `NUM_PORTS`, so the last-granted port has lowest priority.
- **Not defined:** fixed priority with port 0 highest. No pointer register is implemented.

## Structure
- **Package `ahb_mtx_pkg`:**
  - HTRANS and HBURST encoding constants.
  - `burst_beats_m1(hburst)` function returning 4 bits.
  - `ARB_MAX_PORTS`=8.
- **Sub-module `ahb_mtx_prio_pick`:** combinational.
  - Inputs: NUM_PORTS-wide candidate vector and a start index.
  - Outputs: `found` and the selected index.
  - Used with start=0 in fixed-priority mode.

## Test plan
- **Fixed priority:** NUM_PORTS=4; `req_port`=4'b1010 with `HREADYM`=1 -> `addr_in_port`=1, `no_port`=0 after one edge. Then `req_port`=0, `HSELM`=0 -> `no_port`=1.
- **INCR8 hold:** port 2 issues NONSEQ INCR8. Port 0 requests from beat 2 -> `addr_in_port` stays 2 and `arb_hold`=1 for 7 edges, then switches to 0 at the edge accepting beat 8.
- **Early termination:** WRAP4 NONSEQ, one SEQ, then IDLE -> `burst_cnt` clears and a pending port 0 request is granted at that edge.
- **Lock and wait states:** `HMASTLOCKM`=1 with all `req_port` set -> grant unchanged. With `HREADYM`=0 for 3 cycles -> no output changes.
- **Round robin** (macro defined): all four ports requesting continuously with SINGLE transfers -> grant sequence 0,1,2,3,0.
- **Asynchronous reset:** assert `HRESETn` low mid-INCR16 -> `no_port`=1, `addr_in_port`=0 and `arb_hold`=0 without a clock edge.
